mc_main_control: RTL
====================

Name: mc_main_control

Overview:
- Main control FSM for the multicycle MIPS datapath.
- Sits directly upstream of the ALU control decoder and drives its 2-bit alu_op input.
- Sequences each instruction through fetch/decode/execute/memory/writeback states and produces all datapath enables and mux selects.
- Stalls on a memory ready handshake during memory accesses.

Parameters:
- OP_RTYPE, 6'b000000, R-type opcode
- OP_LW, 6'b100011, load word opcode
- OP_SW, 6'b101011, store word opcode
- OP_BEQ, 6'b000100, branch-equal opcode
- OP_J, 6'b000010, jump opcode
- OP_ADDI, 6'b001000, add-immediate opcode (used only with the optional feature)

Ports:
- clk  in  1  system clock; all state changes on the rising edge
- rst_n  in  1  asynchronous active-low reset
- opcode  in  6  instr[31:26] from the instruction register; stable outside FETCH
- mem_ready  in  1  memory completes the current access this cycle
- mem_read  out  1  memory read strobe
- mem_write  out  1  memory write strobe
- iord  out  1  address select: 0 = PC, 1 = ALUOut
- ir_write  out  1  load instruction register
- pc_write  out  1  unconditional PC load
- branch  out  1  PC load qualified by ALU zero
- pc_src  out  2  PC source: 00 = ALU result, 01 = ALUOut, 10 = jump target
- alu_src_a  out  1  ALU A select: 0 = PC, 1 = register A
- alu_src_b  out  2  ALU B select: 00 = register B, 01 = constant 4, 10 = sign-extended immediate, 11 = sign-extended immediate << 2
- alu_op  out  2  to ALU control: 00 = add, 01 = subtract, 10 = use funct
- reg_dst  out  1  register write address: 0 = rt, 1 = rd
- mem_to_reg  out  1  register write data: 0 = ALUOut, 1 = MDR
- reg_write  out  1  register file write enable
- illegal_op  out  1  unrecognised opcode detected
- instr_done  out  1  one-cycle pulse, instruction retired
- state  out  4  current state, for debug

Behaviour:
- State register, 4 bits, asynchronous reset to FETCH (0).
- State encoding: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, RTEX=6, RTWB=7, BEQEX=8, ADDIEX=9, ADDIWB=10, JEX=11. Codes 12-15 are illegal and return to FETCH on the next edge.
- Outputs are decoded from state; they are combinational except instr_done. Unlisted outputs are 0 in each state.
- While rst_n=0: mem_read, mem_write, ir_write, pc_write, branch and reg_write are forced to 0; instr_done is 0.
- FETCH:
  - Outputs: mem_read=1, alu_src_b=01, alu_op=00.
  - ir_write=pc_write=mem_ready, so the enables pulse only on the completing cycle.
  - Transition: stay in FETCH while mem_ready=0; go to DECODE when mem_ready=1.
- DECODE:
  - Outputs: alu_src_b=11, alu_op=00.
  - Transition by opcode: LW/SW to MEMADR; RTYPE to RTEX; BEQ to BEQEX; J to JEX; any other value to FETCH.
  - illegal_op=1 combinationally when the opcode is not recognised.
- MEMADR:
  - Outputs: alu_src_a=1, alu_src_b=10, alu_op=00.
  - Transition: LW to MEMRD, otherwise MEMWR.
- MEMRD:
  - Outputs: iord=1, mem_read=1.
  - Transition: hold until mem_ready=1, then MEMWB.
- MEMWB: mem_to_reg=1, reg_dst=0, reg_write=1; then FETCH.
- MEMWR:
  - Outputs: iord=1, mem_write=1, held for the whole stall.
  - Transition: hold until mem_ready=1, then FETCH.
- RTEX: alu_src_a=1, alu_src_b=00, alu_op=10; then RTWB.
- RTWB: reg_dst=1, reg_write=1; then FETCH.
- BEQEX: alu_src_a=1, alu_op=01, pc_src=01, branch=1; then FETCH.
- JEX: pc_src=10, pc_write=1; then FETCH.
- instr_done: registered, 1 for exactly the first cycle in FETCH after leaving MEMWB, MEMWR (with mem_ready), RTWB, BEQEX, JEX or ADDIWB. It is not asserted after an illegal-opcode return.
- Cycle counts with mem_ready tied to 1: LW 5, SW 4, R-type 4, BEQ 3, J 3, ADDI 4.
- mem_ready is ignored outside FETCH, MEMRD and MEMWR.
- Reset asserted mid-instruction: immediate return to FETCH; no partial writes afterwards.

Optional Feature:
- Macro: MC_ADDI_EN.
- Defined:
  - DECODE with opcode OP_ADDI goes to ADDIEX.
  - ADDIEX: alu_src_a=1, alu_src_b=10, alu_op=00; then ADDIWB.
  - ADDIWB: reg_dst=0, mem_to_reg=0, reg_write=1; then FETCH.
- Not defined:
  - OP_ADDI is treated as illegal (illegal_op=1, return to FETCH).
  - States 9 and 10 are unreachable and are handled as illegal codes.

Test Plan:
- Reset and hold rst_n=0 for 3 cycles, mem_ready=1 -> state=0, all write enables 0; after release, ir_write=pc_write=1 in the first cycle.
- LW (opcode 100011), mem_ready=1 -> states 0,1,2,3,4,0; reg_write=1 only in state 4 with mem_to_reg=1; instr_done=1 on the return to 0.
- SW with mem_ready low for 3 cycles in MEMWR -> state stays 5 for 4 cycles with mem_write=1 and iord=1 throughout, then 0.
- R-type (000000) then BEQ (000100) -> alu_op=10 in RTEX and reg_write with reg_dst=1 in RTWB; BEQ shows alu_op=01, branch=1, pc_src=01 in state 8.
- J (000010) -> state 11 with pc_src=10, pc_write=1; opcode 111111 -> illegal_op=1 in DECODE, next state 0, instr_done stays 0.
- ADDI (001000) -> with MC_ADDI_EN: states 0,1,9,10,0 and reg_write=1 with reg_dst=0 in state 10; without it: illegal_op=1 and return to 0.

Source files
------------

// File: rtl/mc_main_control.sv
// Main control FSM for the multicycle MIPS datapath: sequences fetch/decode/execute/
// memory/writeback and decodes datapath controls from state. Optional ADDI support: MC_ADDI_EN.
module mc_main_control #(
  parameter logic [5:0] OP_RTYPE = 6'b000000,
  parameter logic [5:0] OP_LW    = 6'b100011,
  parameter logic [5:0] OP_SW    = 6'b101011,
  parameter logic [5:0] OP_BEQ   = 6'b000100,
  parameter logic [5:0] OP_J     = 6'b000010,
  parameter logic [5:0] OP_ADDI  = 6'b001000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] opcode,
  input  logic       mem_ready,
  output logic       mem_read,
  output logic       mem_write,
  output logic       iord,
  output logic       ir_write,
  output logic       pc_write,
  output logic       branch,
  output logic [1:0] pc_src,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       reg_write,
  output logic       illegal_op,
  output logic       instr_done,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    FETCH  = 4'd0,  DECODE = 4'd1,  MEMADR = 4'd2,  MEMRD  = 4'd3,
    MEMWB  = 4'd4,  MEMWR  = 4'd5,  RTEX   = 4'd6,  RTWB   = 4'd7,
    BEQEX  = 4'd8,  ADDIEX = 4'd9,  ADDIWB = 4'd10, JEX    = 4'd11
  } state_t;

  state_t state_q;
  state_t state_d;
  state_t decode_next;
  logic   op_known;
  logic   retire;

  // Opcode dispatch out of DECODE; unrecognised opcodes fall back to FETCH.
  always_comb begin
    decode_next = FETCH;
    op_known    = 1'b1;
    case (opcode)
      OP_LW, OP_SW: decode_next = MEMADR;
      OP_RTYPE:     decode_next = RTEX;
      OP_BEQ:       decode_next = BEQEX;
      OP_J:         decode_next = JEX;
`ifdef MC_ADDI_EN
      OP_ADDI:      decode_next = ADDIEX;
`else
      OP_ADDI:      op_known    = 1'b0;
`endif
      default:      op_known    = 1'b0;
    endcase
  end

  always_comb begin
    state_d = FETCH;
    retire  = 1'b0;
    case (state_q)
      FETCH:  state_d = mem_ready ? DECODE : FETCH;
      DECODE: state_d = decode_next;
      MEMADR: state_d = (opcode == OP_LW) ? MEMRD : MEMWR;
      MEMRD:  state_d = mem_ready ? MEMWB : MEMRD;
      MEMWB:  retire  = 1'b1;
      MEMWR: begin
        state_d = mem_ready ? FETCH : MEMWR;
        retire  = mem_ready;
      end
      RTEX:   state_d = RTWB;
      RTWB:   retire  = 1'b1;
      BEQEX:  retire  = 1'b1;
      JEX:    retire  = 1'b1;
`ifdef MC_ADDI_EN
      ADDIEX: state_d = ADDIWB;
      ADDIWB: retire  = 1'b1;
`endif
      default: state_d = FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= FETCH;
      instr_done <= 1'b0;
    end else begin
      state_q    <= state_d;
      instr_done <= retire;
    end
  end

  assign state = state_q;

  always_comb begin
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    iord       = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    branch     = 1'b0;
    pc_src     = 2'b00;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'b00;
    alu_op     = 2'b00;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    reg_write  = 1'b0;
    illegal_op = 1'b0;
    case (state_q)
      FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = 2'b01;
        ir_write  = mem_ready;
        pc_write  = mem_ready;
      end
      DECODE: begin
        alu_src_b  = 2'b11;
        illegal_op = ~op_known;
      end
      MEMADR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
      end
      MEMRD: begin
        iord     = 1'b1;
        mem_read = 1'b1;
      end
      MEMWB: begin
        mem_to_reg = 1'b1;
        reg_write  = 1'b1;
      end
      MEMWR: begin
        iord      = 1'b1;
        mem_write = 1'b1;
      end
      RTEX: begin
        alu_src_a = 1'b1;
        alu_op    = 2'b10;
      end
      RTWB: begin
        reg_dst   = 1'b1;
        reg_write = 1'b1;
      end
      BEQEX: begin
        alu_src_a = 1'b1;
        alu_op    = 2'b01;
        pc_src    = 2'b01;
        branch    = 1'b1;
      end
      JEX: begin
        pc_src   = 2'b10;
        pc_write = 1'b1;
      end
`ifdef MC_ADDI_EN
      ADDIEX: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
      end
      ADDIWB: reg_write = 1'b1;
`endif
      default: ;
    endcase
    // Reset suppresses every strobe that could alter memory, PC, IR or registers.
    if (!rst_n) begin
      mem_read  = 1'b0;
      mem_write = 1'b0;
      ir_write  = 1'b0;
      pc_write  = 1'b0;
      branch    = 1'b0;
      reg_write = 1'b0;
    end
  end

endmodule
